// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_adder_pkg : state encoding and sizing helpers for serial_adder
// Revision 1.0
// ----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The spare encoding is named so the next-state logic can recover from it.
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RUN     = ST_RUN,
    DONE    = ST_DONE,
    ILLEGAL = 2'd3
  } state_e;

  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fullAdder_byHalfAdder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fullAdder_byHalfAdder : one-bit full adder built from two half-adder stages
// Revision 1.0
// ----------------------------------------------------------------------------
module fullAdder_byHalfAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_ha0_sum;
  logic w_ha0_carry;
  logic w_ha1_carry;

  assign w_ha0_sum   = a ^ b;
  assign w_ha0_carry = a & b;
  assign w_ha1_carry = w_ha0_sum & cin;

  assign sum  = w_ha0_sum ^ cin;
  assign cout = w_ha0_carry | w_ha1_carry;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_adder : LSB-first bit-serial adder, one sum bit per clock
// Revision 1.0
// ----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] ws_q, ws_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] ws_shift;

  fullAdder_byHalfAdder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in order.
  generate
    if (WIDTH == 1) begin : g_ws_single
      assign ws_shift = fa_sum;
    end else begin : g_ws_multi
      assign ws_shift = {fa_sum, ws_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    ws_d    = ws_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          ws_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        ws_d    = ws_shift;
        if (cnt_q == LAST_BIT) begin
          sum_d   = ws_shift;
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      ws_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      ws_q    <= ws_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_adder : directed vector bench for serial_adder (WIDTH=8 and 1)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vecs [9];
  logic [1:0] exp1 [8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // One WIDTH=8 operation; done must appear at the 9th falling edge after E0.
  task automatic op8(input vec_t v, input int idx);
    int  n;
    logic bad_busy;
    @(negedge clk);
    a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    bad_busy = 1'b0;
    chk($sformatf("busy_rise[%0d]", idx), busy8, 1);
    while (!done8 && n < 40) begin
      if (!busy8) bad_busy = 1'b1;
      @(negedge clk);
      n++;
    end
    chk($sformatf("busy_hold[%0d]", idx), bad_busy, 0);
    chk($sformatf("done_latency[%0d]", idx), n, 9);
    chk($sformatf("sum[%0d]", idx), sum8, v.s);
    chk($sformatf("cout[%0d]", idx), cout8, v.co);
    @(negedge clk);
    chk($sformatf("done_width[%0d]", idx), done8, 0);
    chk($sformatf("busy_fall[%0d]", idx), busy8, 0);
  endtask

  task automatic op1(input int i, input logic [1:0] exp);
    int n;
    @(negedge clk);
    a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("w1_latency[%0d]", i), n, 2);
    chk($sformatf("w1_result[%0d]", i), {cout1, sum1}, exp);
    @(negedge clk);
    chk($sformatf("w1_idle[%0d]", i), {busy1, done1}, 2'b00);
  endtask

  initial begin
    int   pulses;
    int   first;
    int   prev;
    logic bad_gap;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    // Index is {a,b,cin}; value is {cout,sum}.
    exp1[0] = 2'd0; exp1[1] = 2'd1; exp1[2] = 2'd1; exp1[3] = 2'd2;
    exp1[4] = 2'd1; exp1[5] = 2'd2; exp1[6] = 2'd2; exp1[7] = 2'd3;

    repeat (2) @(negedge clk);
    chk("rst_busy_done", {busy8, done8}, 2'b00);
    chk("rst_sum_cout", {cout8, sum8}, 9'h000);
    chk("rst_w1", {busy1, done1, cout1, sum1}, 4'b0000);
    rst_n = 1'b1;

    foreach (vecs[i]) op8(vecs[i], i);

    // Starts during RUN and DONE must be dropped.
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      if (done8) pulses++;
      if (n == 4) chk("sum_stable_in_run", sum8, 8'h47);
      if (n == 3) begin
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
      end else if (n == 9) begin
        a8 = 8'h77; b8 = 8'h77; cin8 = 1'b0; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignored_done_count", pulses, 1);
    chk("ignored_sum", {cout8, sum8}, 9'h033);
    chk("ignored_no_restart", busy8, 0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    pulses = 0; first = -1; prev = 0; bad_gap = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done8) begin
        if (first < 0) first = n;
        else if (n - prev != 10) bad_gap = 1'b1;
        prev = n;
        pulses++;
        if ({cout8, sum8} !== 9'h003) bad_gap = 1'b1;
      end
    end
    start8 = 1'b0;
    chk("held_done_count", pulses, 3);
    chk("held_first_done", first, 9);
    chk("held_spacing_and_sum", bad_gap, 0);
    repeat (12) @(negedge clk);
    chk("held_drain_idle", busy8, 0);

    // Asynchronous reset in the 4th RUN cycle.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_done", {busy8, done8}, 2'b00);
    chk("abort_sum_cout", {cout8, sum8}, 9'h000);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    op8('{8'h10, 8'h20, 1'b0, 8'h30, 1'b0}, 100);

    for (int i = 0; i < 8; i++) op1(i, exp1[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder. It captures two WIDTH-bit operands and a carry-in, then produces one sum bit per clock by feeding LSB-first operand bits through a single full-adder cell, holding the carry in a flip-flop between cycles. It sits directly upstream of the existing full-adder cell, which it instantiates as its arithmetic stage. It is the area-minimal alternative to a ripple-carry array when latency is not critical.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range ≥ 1.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; the result is valid.
- sum  out  WIDTH  result register; holds the last completed sum.
- cout  out  1  result carry-out; holds the last completed carry.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, start=1:**
  - load shift registers A_sr←a, B_sr←b.
  - load carry_ff←cin.
  - clear bit counter cnt←0 and the working sum shift register.
  - next state RUN.
- **IDLE, start=0:** remain in IDLE; all registers hold.
- **RUN, each edge:**
  - the full-adder cell computes A_sr[0] + B_sr[0] + carry_ff.
  - its sum bit shifts into the working-sum MSB (right shift).
  - A_sr and B_sr shift right.
  - carry_ff←cell carry.
  - cnt←cnt+1.
- **RUN, edge where cnt==WIDTH-1:**
  - do the bit step above.
  - transfer the completed working sum to the sum output register and the final carry to cout.
  - next state DONE.
- **DONE:** done=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Start handling:
  - start in RUN or DONE is ignored and not queued.
  - if start is held continuously high, a new operation is accepted on the first IDLE cycle.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned; no overflow flag.
- Counter width is max(1, $clog2(WIDTH)). It never wraps past WIDTH-1.
- WIDTH=1: RUN lasts exactly one edge.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, done=0, busy=0.
  - sum=0, cout=0, carry_ff=0, cnt=0, all shift registers 0.
- Reset mid-operation aborts: no done pulse, and sum/cout return to 0. The first start after rst_n deasserts is accepted normally.
- Latency, with start accepted at edge E0:
  - bit steps occur at E1..E_WIDTH.
  - sum and cout update at E_WIDTH.
  - done is high in the cycle between E_WIDTH and E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles.
- busy rises after E0 and falls after E_WIDTH+1.
- sum and cout change only at E_WIDTH or on reset. They are stable at all other times, including during a following RUN.
- done and busy are registered outputs; there is no combinational path from any input to any output.

## Structure
- Package serial_adder_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2; encoding 2'd3 recovers to IDLE.
  - the counter-width function.
- Sub-module: one instance of the team's existing fullAdder_byHalfAdder cell, used as the per-bit arithmetic stage.
- All sequential logic lives in serial_adder.

## Test plan
All scenarios use WIDTH=8 unless stated.
- a=0x5A, b=0x3C, cin=0, single start pulse -> done exactly 9 cycles after the start edge; sum=0x96, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full carry propagation).
- Start pulses during RUN and during DONE with different operands -> ignored; result equals the first operation only; a single done pulse.
- Start held high for 30 cycles, operands constant 0x01+0x02 -> three done pulses spaced 10 cycles apart, each with sum=0x03 and cout=0.
- rst_n asserted at the 4th RUN cycle -> immediate busy=0, sum=0, cout=0; no done. After release, a=0x10, b=0x20 -> sum=0x30.
- WIDTH=1 sweep of all 8 {a,b,cin} combinations -> {cout,sum} equals the 2-bit arithmetic sum; done 2 cycles after each start edge.
